// File: rtl/rng_sched.sv
// rng_sched: shares one `rng` range generator between N_REQ cfg requesters.
//
// A requester is granted in IDLE and holds the `rng` cfg port for a whole
// range, up to and including the eot element. The owner index tags every
// element passed downstream. There is one idle (arbitration) cycle between
// consecutive ranges.
//
// Build option:
//   RNG_SCHED_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                            undefined -> round-robin after rr_ptr (default)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     per-requester cfg handshake (N_REQ bits)
//   req_data            per-requester cfg, requester i at [i*W_CFG +: W_CFG]
//   cfg_valid/ready     cfg stream to the shared `rng`
//   cfg_data            cfg word of the current owner
//   rng_valid/ready     `rng` dout stream
//   rng_data            `rng` element, eot at MSB
//   dout_valid/ready    tagged output stream to the consumer
//   dout_data           element data, eot at MSB
//   dout_id             owner index of the current element
module rng_sched #(
  parameter int N_REQ  = 4,
  parameter int W_CFG  = 48,
  parameter int W_DOUT = 17,
  parameter int W_ID   = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*W_CFG-1:0] req_data,
  output logic                   cfg_valid,
  input  logic                   cfg_ready,
  output logic [W_CFG-1:0]       cfg_data,
  input  logic                   rng_valid,
  output logic                   rng_ready,
  input  logic [W_DOUT-1:0]      rng_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [W_DOUT-1:0]      dout_data,
  output logic [W_ID-1:0]        dout_id
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W_ID-1:0] grant_q, grant_d;
  logic [W_ID-1:0] winner;
  logic            any_req;
  logic            eot_hs;

  assign any_req = |req_valid;

`ifdef RNG_SCHED_FIXED_PRIO_EN
  // Lowest requesting index wins; scanning downward lets the lowest overwrite.
  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) winner = W_ID'(i);
    end
  end
`else
  logic [W_ID-1:0]    rr_ptr_q, rr_ptr_d;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;

  // Rotate the request vector so bit 0 is the requester right after rr_ptr;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    req_dbl = {req_valid, req_valid};
    req_rot = N_REQ'(req_dbl >> (int'(rr_ptr_q) + 1));
    winner  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) winner = W_ID'((int'(rr_ptr_q) + 1 + j) % N_REQ);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
`ifndef RNG_SCHED_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    req_ready  = '0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    rng_ready  = 1'b0;
    dout_valid = 1'b0;
    dout_data  = '0;
    dout_id    = '0;
    eot_hs     = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // cfg path of the owner; `rng` only raises cfg_ready on its eot
        // handshake, so that handshake marks the end of the range.
        cfg_valid          = req_valid[grant_q];
        cfg_data           = req_data[grant_q*W_CFG +: W_CFG];
        req_ready[grant_q] = cfg_ready;
        // Element path is a zero-latency pass-through with the owner tag.
        dout_valid = rng_valid;
        rng_ready  = dout_ready;
        dout_data  = rng_data;
        dout_id    = grant_q;
        eot_hs     = req_valid[grant_q] & cfg_ready;
        if (eot_hs) begin
`ifndef RNG_SCHED_FIXED_PRIO_EN
          rr_ptr_d = grant_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
`ifndef RNG_SCHED_FIXED_PRIO_EN
      // Start just below 0 so requester 0 wins the first arbitration.
      rr_ptr_q <= W_ID'(N_REQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
`ifndef RNG_SCHED_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_rng_sched.sv
// Directed testbench for rng_sched. A small behavioural `rng` stands in for
// the shared generator: it emits base + k*incr for k = 0..cnt-1 while cfg is
// valid, sets eot on the last element and raises cfg_ready only on that
// element's handshake.
module tb_rng_sched;

  localparam int N  = 4;
  localparam int WC = 48;
  localparam int WD = 17;
  localparam int WI = 2;

`ifdef RNG_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*WC-1:0] req_data;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [WC-1:0]   cfg_data;
  logic            rng_valid;
  logic            rng_ready;
  logic [WD-1:0]   rng_data;
  logic            dout_valid;
  logic            dout_ready;
  logic [WD-1:0]   dout_data;
  logic [WI-1:0]   dout_id;

  int n_checks = 0;
  int n_errors = 0;

  rng_sched #(.N_REQ(N), .W_CFG(WC), .W_DOUT(WD), .W_ID(WI)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .rng_valid  (rng_valid),
    .rng_ready  (rng_ready),
    .rng_data   (rng_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_id    (dout_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural rng: cfg word is {incr, cnt, base}, 16 bits each.
  logic [15:0] elem_idx;
  logic [15:0] m_base, m_cnt, m_incr;
  logic        m_eot;
  assign m_base    = cfg_data[15:0];
  assign m_cnt     = cfg_data[31:16];
  assign m_incr    = cfg_data[47:32];
  assign m_eot     = (elem_idx == m_cnt - 16'd1);
  assign rng_valid = cfg_valid;
  assign rng_data  = {m_eot, 16'(m_base + elem_idx * m_incr)};
  assign cfg_ready = rng_valid & rng_ready & m_eot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) elem_idx <= '0;
    else if (rng_valid && rng_ready) elem_idx <= m_eot ? 16'd0 : elem_idx + 16'd1;
  end

  // Log of every element accepted downstream: {id, data}.
  logic [WI+WD-1:0] out_log[$];
  always @(posedge clk) begin
    if (!rst && dout_valid && dout_ready) out_log.push_back({dout_id, dout_data});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int i, input int incr, input int cnt, input int base);
    req_data[i*WC +: WC] = {16'(incr), 16'(cnt), 16'(base)};
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  int w1, w2;

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    dout_ready = 1'b1;

    // Reset state
    to_neg();
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rng_ready", rng_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_id", dout_id, 0);

    // Single requester 0, base 0 incr 1 cnt 3
    to_pos();
    rst       = 1'b0;
    req_valid = 4'b0001;
    set_cfg(0, 1, 3, 0);
    to_neg();
    chk("t1_arb_latency", cfg_valid, 0);
    chk("t1_arb_dout_valid", dout_valid, 0);
    to_pos(); to_neg();
    chk("t1_e0_cfg_valid", cfg_valid, 1);
    chk("t1_e0_valid", dout_valid, 1);
    chk("t1_e0_data", dout_data, 64'h00000);
    chk("t1_e0_id", dout_id, 0);
    chk("t1_e0_req_ready", req_ready, 0);
    to_pos(); to_neg();
    chk("t1_e1_data", dout_data, 64'h00001);
    chk("t1_e1_req_ready", req_ready, 0);
    to_pos(); to_neg();
    chk("t1_e2_data", dout_data, 64'h10002);
    chk("t1_e2_req_ready", req_ready, 4'b0001);
    to_pos();
    req_valid = 4'b0000;
    to_neg();
    chk("t1_idle_cfg_valid", cfg_valid, 0);
    chk("t1_idle_dout_valid", dout_valid, 0);

    // All four requesters held, cnt=2 each, base = 16*i
    to_pos();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_cfg(i, 1, 2, 16 * i);
    req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      int ph;
      int own;
      ph  = c % 3;
      own = FIXED ? 0 : (c / 3) % 4;
      to_neg();
      chk("t2_valid", dout_valid, 64'(ph != 0));
      if (ph != 0) begin
        chk("t2_id", dout_id, 64'(own));
        chk("t2_data", dout_data, 64'({(ph == 2), 16'(own * 16 + ph - 1)}));
      end
      to_pos();
    end
    req_valid = 4'b0000;

    // Backpressure on requester 1: base 100 incr 2 cnt 3
    out_log.delete();
    req_valid = 4'b0010;
    set_cfg(1, 2, 3, 100);
    to_neg();
    chk("t3_idle", dout_valid, 0);
    to_pos(); dout_ready = 1'b1; to_neg();
    chk("t3_e0_data", dout_data, 64'd100);
    chk("t3_e0_rng_ready", rng_ready, 1);
    chk("t3_e0_id", dout_id, 1);
    to_pos(); dout_ready = 1'b0; to_neg();
    chk("t3_s0_data", dout_data, 64'd102);
    chk("t3_s0_rng_ready", rng_ready, 0);
    chk("t3_s0_valid", dout_valid, 1);
    to_pos(); to_neg();
    chk("t3_s1_data", dout_data, 64'd102);
    chk("t3_s1_id", dout_id, 1);
    to_pos(); dout_ready = 1'b1; to_neg();
    chk("t3_e1_data", dout_data, 64'd102);
    chk("t3_e1_rng_ready", rng_ready, 1);
    to_pos(); to_neg();
    chk("t3_e2_data", dout_data, 64'h10068);
    chk("t3_e2_req_ready", req_ready, 4'b0010);
    chk("t3_e2_id", dout_id, 1);
    to_pos();
    req_valid = 4'b0000;
    to_neg();
    chk("t3_end_valid", dout_valid, 0);
    chk("t3_log_size", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("t3_log0", out_log[0], {2'd1, 17'h00064});
      chk("t3_log1", out_log[1], {2'd1, 17'h00066});
      chk("t3_log2", out_log[2], {2'd1, 17'h10068});
    end

    // Requester 2 owns the range; requester 1 arrives mid-range
    to_pos();
    req_valid = 4'b0100;
    set_cfg(2, 1, 3, 200);
    to_neg();
    chk("t4_idle", dout_valid, 0);
    to_pos(); to_neg();
    chk("t4_e0_id", dout_id, 2);
    chk("t4_e0_data", dout_data, 64'd200);
    to_pos();
    req_valid = 4'b0110;
    set_cfg(1, 1, 1, 300);
    set_cfg(3, 1, 1, 400);
    to_neg();
    chk("t4_e1_req_ready", req_ready, 0);
    chk("t4_e1_id", dout_id, 2);
    chk("t4_e1_data", dout_data, 64'd201);
    to_pos(); to_neg();
    chk("t4_e2_req_ready", req_ready, 4'b0100);
    chk("t4_e2_data", dout_data, 64'h100ca);
    to_pos();
    req_valid = 4'b1010;
    w1 = FIXED ? 1 : 3;
    w2 = FIXED ? 3 : 1;
    to_neg();
    chk("t4_bubble", dout_valid, 0);
    chk("t4_bubble_req_ready", req_ready, 0);
    to_pos(); to_neg();
    chk("t4_w1_id", dout_id, 64'(w1));
    chk("t4_w1_data", dout_data, (w1 == 3) ? 64'h10190 : 64'h1012c);
    chk("t4_w1_req_ready", req_ready, 64'(1 << w1));
    to_pos();
    req_valid = 4'b1010 & ~(4'(1 << w1));
    to_neg();
    chk("t4_bubble2", dout_valid, 0);
    to_pos(); to_neg();
    chk("t4_w2_id", dout_id, 64'(w2));
    chk("t4_w2_req_ready", req_ready, 64'(1 << w2));
    to_pos();
    req_valid = 4'b0000;
    to_neg();
    chk("t4_end_valid", dout_valid, 0);

    // Reset during element 2 of a 5-element range
    to_pos();
    req_valid = 4'b0100;
    set_cfg(2, 1, 5, 500);
    to_neg();
    to_pos(); to_neg();
    chk("t5_e0_data", dout_data, 64'd500);
    to_pos(); to_neg();
    chk("t5_e1_data", dout_data, 64'd501);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_cfg_valid", cfg_valid, 0);
    chk("t5_rst_dout_valid", dout_valid, 0);
    chk("t5_rst_req_ready", req_ready, 0);
    chk("t5_rst_rng_ready", rng_ready, 0);
    chk("t5_rst_dout_id", dout_id, 0);
    chk("t5_rst_dout_data", dout_data, 0);
    to_pos();
    rst       = 1'b0;
    req_valid = 4'b0101;
    set_cfg(0, 1, 1, 7);
    to_neg();
    chk("t5_idle", dout_valid, 0);
    to_pos(); to_neg();
    chk("t5_first_id", dout_id, 0);
    chk("t5_first_data", dout_data, 64'h10007);
    chk("t5_first_req_ready", req_ready, 4'b0001);
    to_pos();
    req_valid = 4'b0000;
    to_neg();
    chk("t5_end_valid", dout_valid, 0);

    // Requesters 1 and 3 held, single-element ranges
    to_pos();
    set_cfg(1, 1, 1, 600);
    set_cfg(3, 1, 1, 700);
    req_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      int ph;
      int own;
      ph  = c % 2;
      own = FIXED ? 1 : (((c / 2) % 2 == 1) ? 3 : 1);
      to_neg();
      chk("t6_valid", dout_valid, 64'(ph));
      if (ph != 0) begin
        chk("t6_id", dout_id, 64'(own));
        chk("t6_data", dout_data, (own == 1) ? 64'h10258 : 64'h102bc);
      end
      to_pos();
    end
    req_valid = 4'b0000;
    to_neg();
    chk("t6_end_valid", dout_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
